// File: rtl/ex_stage_pkg.sv
// Shared encodings for the RV32 execute stage: result classes, ALU opcodes,
// divider FSM states and datapath widths.
package ex_stage_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_CNT_W  = 6;
  localparam int REG_ADDR_W = 5;
  localparam int ALUSEL_W   = 3;
  localparam int ALUOP_W    = 8;

  typedef logic [ALUSEL_W-1:0] alusel_t;
  typedef logic [ALUOP_W-1:0]  aluop_t;

  localparam alusel_t EXE_RES_NOP        = 3'd0;
  localparam alusel_t EXE_RES_LOGIC      = 3'd1;
  localparam alusel_t EXE_RES_SHIFT      = 3'd2;
  localparam alusel_t EXE_RES_ARITH      = 3'd3;
  localparam alusel_t EXE_RES_LINK       = 3'd4;
  localparam alusel_t EXE_RES_LOAD_STORE = 3'd5;
  localparam alusel_t EXE_RES_DIV        = 3'd6;

  localparam aluop_t EXE_NOP_OP  = 8'd0;
  localparam aluop_t EXE_AND_OP  = 8'd1;
  localparam aluop_t EXE_OR_OP   = 8'd2;
  localparam aluop_t EXE_XOR_OP  = 8'd3;
  localparam aluop_t EXE_SLL_OP  = 8'd4;
  localparam aluop_t EXE_SRL_OP  = 8'd5;
  localparam aluop_t EXE_SRA_OP  = 8'd6;
  localparam aluop_t EXE_ADD_OP  = 8'd7;
  localparam aluop_t EXE_SUB_OP  = 8'd8;
  localparam aluop_t EXE_SLT_OP  = 8'd9;
  localparam aluop_t EXE_SLTU_OP = 8'd10;
  localparam aluop_t EXE_JAL_OP  = 8'd11;
  localparam aluop_t EXE_JALR_OP = 8'd12;
  localparam aluop_t EXE_LW_OP   = 8'd13;
  localparam aluop_t EXE_SW_OP   = 8'd14;
  localparam aluop_t EXE_DIV_OP  = 8'd15;
  localparam aluop_t EXE_DIVU_OP = 8'd16;
  localparam aluop_t EXE_REM_OP  = 8'd17;
  localparam aluop_t EXE_REMU_OP = 8'd18;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
    return c ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU (one quotient bit per cycle).
// EX_DIV_EARLY_EN: divide-by-zero and signed overflow jump straight from IDLE to DONE.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            want_rem,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            hold,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  logic [1:0]           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 want_rem_q, want_rem_d;

  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   rem_sh, diff;

  always_comb begin
    mag_a  = neg_if(signed_op && opa[XLEN-1], opa);
    mag_b  = neg_if(signed_op && opb[XLEN-1], opb);
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};

    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    want_rem_d = want_rem_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          quo_d      = mag_a;
          rem_d      = '0;
          dvs_d      = mag_b;
          // A zero divisor must leave the all-ones quotient uncorrected.
          neg_quo_d  = signed_op && (opa[XLEN-1] ^ opb[XLEN-1]) && (opb != '0);
          neg_rem_d  = signed_op && opa[XLEN-1];
          want_rem_d = want_rem;
          state_d    = DIV_BUSY;
`ifdef EX_DIV_EARLY_EN
          if (opb == '0) begin
            quo_d   = '1;
            rem_d   = mag_a;
            state_d = DIV_DONE;
          end else if (signed_op && opa == {1'b1, {(XLEN-1){1'b0}}} && opb == '1) begin
            quo_d   = {1'b1, {(XLEN-1){1'b0}}};
            rem_d   = '0;
            state_d = DIV_DONE;
          end
`endif
        end
      end
      DIV_BUSY: begin
        quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_CNT_W'(XLEN-1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (!hold) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      want_rem_q <= want_rem_d;
    end
  end

  assign result = want_rem_q ? neg_if(neg_rem_q, rem_q) : neg_if(neg_quo_q, quo_q);
  assign busy   = (state_q == DIV_BUSY);
  assign done   = (state_q == DIV_DONE);

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: combinational ALU/shift/link/AGU plus the iterative divider.
// EX_DIV_EARLY_EN (in ex_div) shortens divide-by-zero and signed-overflow latency.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUSEL_W-1:0]   ex_alusel,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [XLEN-1:0]       ex_opv1,
  input  logic [XLEN-1:0]       ex_opv2,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic                  ex_we,
  input  logic [XLEN-1:0]       ex_link_addr,
  input  logic [XLEN-1:0]       ex_mem_offset,
  input  logic [4:0]            stall,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_sdata,
  output logic                  stallreq_ex
);

  logic            is_div;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] div_result;
  logic            div_busy, div_done;
  logic            unused_sigs;

  assign is_div = (ex_alusel == EXE_RES_DIV);
  assign shamt  = ex_opv2[4:0];

  ex_div #(.XLEN(XLEN), .DIV_CNT_W(DIV_CNT_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op ((ex_aluop == EXE_DIV_OP) || (ex_aluop == EXE_REM_OP)),
    .want_rem  ((ex_aluop == EXE_REM_OP) || (ex_aluop == EXE_REMU_OP)),
    .opa       (ex_opv1),
    .opb       (ex_opv2),
    .hold      (stall[3]),
    .result    (div_result),
    .busy      (div_busy),
    .done      (div_done)
  );

  always_comb begin
    alu_res = '0;
    case (ex_aluop)
      EXE_AND_OP:  alu_res = ex_opv1 & ex_opv2;
      EXE_OR_OP:   alu_res = ex_opv1 | ex_opv2;
      EXE_XOR_OP:  alu_res = ex_opv1 ^ ex_opv2;
      EXE_SLL_OP:  alu_res = ex_opv1 << shamt;
      EXE_SRL_OP:  alu_res = ex_opv1 >> shamt;
      EXE_SRA_OP:  alu_res = $signed(ex_opv1) >>> shamt;
      EXE_ADD_OP:  alu_res = ex_opv1 + ex_opv2;
      EXE_SUB_OP:  alu_res = ex_opv1 - ex_opv2;
      EXE_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, $signed(ex_opv1) < $signed(ex_opv2)};
      EXE_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, ex_opv1 < ex_opv2};
      default:     alu_res = '0;
    endcase
  end

  always_comb begin
    mem_wdata = '0;
    if (rst) begin
      case (ex_alusel)
        EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_ARITH: mem_wdata = alu_res;
        EXE_RES_LINK: mem_wdata = ex_link_addr;
        EXE_RES_DIV:  mem_wdata = div_done ? div_result : '0;
        default:      mem_wdata = '0;
      endcase
    end
  end

  // A divide only writes back once its result sits in DONE.
  assign mem_we      = rst && ex_we && (!is_div || div_done);
  assign stallreq_ex = rst && is_div && !div_done;
  assign mem_waddr   = rst ? ex_waddr : '0;
  assign mem_aluop   = rst ? ex_aluop : EXE_NOP_OP;
  assign mem_addr    = rst ? (ex_opv1 + ex_mem_offset) : '0;
  assign mem_sdata   = rst ? ex_opv2 : '0;

  assign unused_sigs = ^{stall[4], stall[2:0], div_busy};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for the combinational paths,
// hand-written sequences for divider latency, DONE hold and mid-divide reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_opv1, ex_opv2, ex_link_addr, ex_mem_offset;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic [4:0]  stall;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_addr, mem_sdata;
  logic [7:0]  mem_aluop;
  logic        stallreq_ex;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_alusel    (ex_alusel),
    .ex_aluop     (ex_aluop),
    .ex_opv1      (ex_opv1),
    .ex_opv2      (ex_opv2),
    .ex_waddr     (ex_waddr),
    .ex_we        (ex_we),
    .ex_link_addr (ex_link_addr),
    .ex_mem_offset(ex_mem_offset),
    .stall        (stall),
    .mem_waddr    (mem_waddr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_addr     (mem_addr),
    .mem_sdata    (mem_sdata),
    .stallreq_ex  (stallreq_ex)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] a, b, link, off;
    logic        we;
    logic [31:0] exp_wdata, exp_addr;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] sel, input logic [7:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic we,
                              input logic [31:0] link, input logic [31:0] off,
                              input logic [31:0] ew, input logic [31:0] ea);
    vec_t v;
    v.sel = sel; v.op = op; v.a = a; v.b = b; v.we = we;
    v.link = link; v.off = off; v.exp_wdata = ew; v.exp_addr = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic [4:0] wa,
                       input logic [31:0] link, input logic [31:0] off);
    ex_alusel = sel; ex_aluop = op; ex_opv1 = a; ex_opv2 = b;
    ex_we = we; ex_waddr = wa; ex_link_addr = link; ex_mem_offset = off;
  endtask

  task automatic drive_nop();
    drive(EXE_RES_NOP, EXE_NOP_OP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_we"}, 32'(mem_we), 32'h0);
    check({tag, "_waddr"}, 32'(mem_waddr), 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_sdata"}, mem_sdata, 32'h0);
    check({tag, "_aluop"}, 32'(mem_aluop), 32'(EXE_NOP_OP));
    check({tag, "_stallreq"}, 32'(stallreq_ex), 32'h0);
  endtask

  // Issue one divide, count stall-request cycles, then check the DONE result.
  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_cycles);
    int cycles;
    @(negedge clk);
    drive(EXE_RES_DIV, op, a, b, 1'b1, 5'd12, 32'h0, 32'h0);
    cycles = 0;
    #1;
    while (stallreq_ex && cycles < 100) begin
      if (cycles == 0) check({name, "_we_busy"}, 32'(mem_we), 32'h0);
      cycles++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall_cycles"}, 32'(cycles), 32'(exp_cycles));
    check({name, "_wdata"}, mem_wdata, exp);
    check({name, "_we_done"}, 32'(mem_we), 32'h1);
    drive_nop();
  endtask

  vec_t vecs[14];
  int   special_cycles;
  int   cyc;

  initial begin
`ifdef EX_DIV_EARLY_EN
    special_cycles = 1;
`else
    special_cycles = 33;
`endif
    vecs[0]  = mk(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h0, 32'h0, 32'h80000000, 32'h7FFFFFFF);
    vecs[1]  = mk(EXE_RES_ARITH, EXE_SUB_OP, 32'h5, 32'h7, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h5);
    vecs[2]  = mk(EXE_RES_ARITH, EXE_SLT_OP, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF);
    vecs[3]  = mk(EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    vecs[4]  = mk(EXE_RES_LOGIC, EXE_AND_OP, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0, 32'hF000F000, 32'hF0F0F0F0);
    vecs[5]  = mk(EXE_RES_LOGIC, EXE_OR_OP, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0, 32'hFFF0FFF0, 32'hF0F0F0F0);
    vecs[6]  = mk(EXE_RES_LOGIC, EXE_XOR_OP, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0, 32'h0FF00FF0, 32'hF0F0F0F0);
    vecs[7]  = mk(EXE_RES_SHIFT, EXE_SLL_OP, 32'h1, 32'h21, 1'b1, 32'h0, 32'h0, 32'h2, 32'h1);
    vecs[8]  = mk(EXE_RES_SHIFT, EXE_SRL_OP, 32'h80000000, 32'h24, 1'b1, 32'h0, 32'h0, 32'h08000000, 32'h80000000);
    vecs[9]  = mk(EXE_RES_SHIFT, EXE_SRA_OP, 32'h80000000, 32'h24, 1'b1, 32'h0, 32'h0, 32'hF8000000, 32'h80000000);
    vecs[10] = mk(EXE_RES_LINK, EXE_JAL_OP, 32'h0, 32'h0, 1'b1, 32'h10000040, 32'h0, 32'h10000040, 32'h0);
    vecs[11] = mk(EXE_RES_LOAD_STORE, EXE_SW_OP, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h00000FFC);
    vecs[12] = mk(EXE_RES_NOP, EXE_NOP_OP, 32'h20, 32'h0, 1'b0, 32'h0, 32'h10, 32'h0, 32'h30);
    vecs[13] = mk(EXE_RES_ARITH, EXE_SLT_OP, 32'h1, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h0, 32'h0, 32'h1);

    // Reset state with live inputs on the ports.
    rst = 1'b0;
    stall = 5'b0;
    drive(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFFFFFF, 32'h1, 1'b1, 5'd5, 32'h44, 32'h8);
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].we, 5'(i + 1),
            vecs[i].link, vecs[i].off);
      #1;
      check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
      check($sformatf("vec%0d_waddr", i), 32'(mem_waddr), 32'(i + 1));
      check($sformatf("vec%0d_aluop", i), 32'(mem_aluop), 32'(vecs[i].op));
      check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_sdata", i), mem_sdata, vecs[i].b);
      check($sformatf("vec%0d_stallreq", i), 32'(stallreq_ex), 32'h0);
    end

    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
    run_div("rem_m7_2", EXE_REM_OP, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
    run_div("div_7_m2", EXE_DIV_OP, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_div("rem_7_m2", EXE_REM_OP, 32'h7, 32'hFFFFFFFE, 32'h1, 33);
    run_div("remu_100_7", EXE_REMU_OP, 32'd100, 32'd7, 32'd2, 33);
    run_div("divu_5_0", EXE_DIVU_OP, 32'h5, 32'h0, 32'hFFFFFFFF, special_cycles);
    run_div("div_m7_0", EXE_DIV_OP, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, special_cycles);
    run_div("rem_m7_0", EXE_REM_OP, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, special_cycles);
    run_div("rem_ovf", EXE_REM_OP, 32'h80000000, 32'hFFFFFFFF, 32'h0, special_cycles);
    run_div("div_ovf", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, special_cycles);

    // DONE held by stall[3], then released back to IDLE.
    @(negedge clk);
    drive(EXE_RES_DIV, EXE_DIVU_OP, 32'd100, 32'd7, 1'b1, 5'd9, 32'h0, 32'h0);
    cyc = 0;
    #1;
    while (stallreq_ex && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("hold_stall_cycles", 32'(cyc), 32'd33);
    stall = 5'b01111;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold%0d_wdata", k), mem_wdata, 32'd14);
      check($sformatf("hold%0d_we", k), 32'(mem_we), 32'h1);
      check($sformatf("hold%0d_stallreq", k), 32'(stallreq_ex), 32'h0);
      if (k < 3) begin
        @(negedge clk);
        #1;
      end
    end
    stall = 5'b0;
    @(negedge clk);
    #1;
    // Back in IDLE with the same divide still presented: a fresh capture stalls again.
    check("hold_release_idle", 32'(stallreq_ex), 32'h1);
    check("hold_release_we", 32'(mem_we), 32'h0);
    drive_nop();

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    drive(EXE_RES_DIV, EXE_DIV_OP, 32'hFFFFFFF9, 32'h2, 1'b1, 5'd3, 32'h0, 32'h0);
    repeat (11) @(negedge clk);
    #1;
    check("midrst_busy", 32'(stallreq_ex), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(EXE_RES_ARITH, EXE_ADD_OP, 32'd3, 32'd4, 1'b1, 5'd7, 32'h0, 32'h0);
    #1;
    check("postrst_add_wdata", mem_wdata, 32'd7);
    check("postrst_add_we", 32'(mem_we), 32'h1);
    check("postrst_add_stallreq", 32'(stallreq_ex), 32'h0);
    run_div("postrst_div", EXE_DIV_OP, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline.
- Consumes the decoded operation registered by the ID/EX pipeline register and produces write-back and memory-access fields for the EX/MEM register.
- Integer ALU, shift, link and address-generation paths are combinational.
- RV32M DIV/DIVU/REM/REMU run on an iterative radix-2 divider FSM. It raises a stall request to the pipeline controller until the result is ready.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_CNT_W, 6, divider iteration counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- ex_alusel  input  `AluSelBus  result class from ID/EX.
- ex_aluop  input  `AluOpBus  operation code from ID/EX.
- ex_opv1  input  `RegBus  operand 1 (rs1 / dividend).
- ex_opv2  input  `RegBus  operand 2 (rs2 / imm / divisor / store data).
- ex_waddr  input  `RegAddrBus  destination register.
- ex_we  input  1  register write enable.
- ex_link_addr  input  `InstAddrBus  return address for JAL/JALR.
- ex_mem_offset  input  `RegBus  load/store offset.
- stall  input  5  controller stall vector; bit 3 holds EX/MEM.
- mem_waddr  output  `RegAddrBus  destination register to EX/MEM.
- mem_we  output  1  write enable to EX/MEM.
- mem_wdata  output  `RegBus  result value.
- mem_aluop  output  `AluOpBus  forwarded aluop for load/store decode.
- mem_addr  output  `RegBus  effective address = opv1 + mem_offset.
- mem_sdata  output  `RegBus  store data = opv2.
- stallreq_ex  output  1  request to stall PC..ID/EX (stall[2:0]).

Behaviour:
- Reset (rst=0):
  - FSM to IDLE; counter, quotient, remainder and captured-operand registers to 0.
  - While rst=0, mem_we=0, mem_wdata=0, mem_waddr=0, mem_addr=0, mem_sdata=0, mem_aluop=`EXE_NOP_OP, stallreq_ex=0.
  - Reset mid-division aborts it; no result is emitted.
- Combinational ops, 0-cycle latency:
  - ADD/SUB wrap mod 2^32.
  - SLT signed, SLTU unsigned; result 0/1.
  - AND/OR/XOR.
  - SLL/SRL/SRA use shift amount opv2[4:0].
  - Link class: wdata = link_addr.
  - Load/store: mem_addr and mem_sdata as above.
  - NOP: mem_we=0.
- Passthrough: mem_waddr and mem_aluop pass through unchanged. mem_we = ex_we except when forced low (reset, or divider not in DONE).
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE, with a div/rem op present: capture magnitudes and sign flags, count=0, go to BUSY; stallreq_ex=1.
  - BUSY: one restoring step per cycle on a 33-bit partial remainder; count++. After count==31, go to DONE. stallreq_ex=1 throughout.
  - DONE: stallreq_ex=0; mem_wdata = sign-corrected quotient or remainder; mem_we = ex_we.
  - Leave DONE for IDLE on a clock edge with stall[3]=0. With stall[3]=1, stay in DONE holding the result.
  - Latency: op arrival to result visible = 33 cycles stallreq_ex=1, then result on cycle 34 (DONE).
- Sign rules:
  - Quotient negative iff signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
- A non-div op present while in IDLE never enters BUSY.
- ID/EX is held by stall[2]=1 during BUSY, so operands are stable. The divider nevertheless uses its captured copies only.

Optional Feature:
- Macro: EX_DIV_EARLY_EN.
- Defined: divide-by-zero and signed overflow go IDLE→DONE directly. Result on cycle 2; stallreq_ex=1 for exactly 1 cycle.
- Undefined: these cases run the full 32 BUSY iterations. Results are identical; only latency differs.

Decomposition:
- Shared package, defines.v: `EXE_DIV_OP/`EXE_DIVU_OP/`EXE_REM_OP/`EXE_REMU_OP, `EXE_RES_DIV, FSM state encodings DIV_IDLE/DIV_BUSY/DIV_DONE, DIV_CNT_W.
- One sub-module: ex_div (FSM + datapath). Interface: start, signed_op, want_rem, opa, opb, hold, result, busy, done.
- ex_stage keeps the combinational ALU and the output mux.

Test Plan:
- ADD opv1=0x7FFFFFFF opv2=1 → mem_wdata=0x80000000 same cycle; stallreq_ex=0.
- SRA opv1=0x80000000 opv2=0x24 → shift 4; mem_wdata=0xF8000000.
- DIV opv1=-7 opv2=2 → stallreq_ex high 33 cycles; DONE: mem_wdata=0xFFFFFFFD. Same operands with REM → 0xFFFFFFFF.
- DIVU opv1=5 opv2=0 → mem_wdata=0xFFFFFFFF. REM 0x80000000 / -1 → 0. With EX_DIV_EARLY_EN defined, stallreq_ex high exactly 1 cycle.
- DIVU 100/7 with stall[3]=1 held 3 cycles in DONE → mem_wdata=14 stable all cycles; IDLE after stall[3] drops.
- Pull rst low in BUSY cycle 10 → outputs 0 and stallreq_ex=0 immediately. After release, an ADD completes normally.
